// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates the UART receiver, buffers bytes in a show-ahead FIFO,
// handles BREAK and flags idle timeouts. Optional EOL tag per entry: UART_RX_CTRL_EOL_EN.
module uart_rx_ctrl #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned IDLE_CYCLES  = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          rx_valid,
  input  logic                          rx_break,
  input  logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          uart_rx_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic                          m_eol,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          break_det,
  output logic                          idle_timeout
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   IDLE_MAX = 16'(IDLE_CYCLES);
  localparam logic [15:0]   QUIET_LAST = 16'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_BREAK} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [15:0]             idle_cnt_q, idle_cnt_d;
  logic [PAYLOAD_BITS-1:0] m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    uart_rx_en_q, uart_rx_en_d;
  logic                    overflow_q, overflow_d;
  logic                    break_det_q, break_det_d;
  logic                    idle_timeout_q, idle_timeout_d;
  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];

  logic brk_rx, push_req, push_ok, drop, pop, quiet_done, head_from_rx, brk_edge;

  assign brk_rx     = rx_valid & rx_break;
  assign push_req   = rx_valid & ~rx_break & (state_q == ST_RUN);
  assign pop        = m_valid_q & m_ready;
  assign push_ok    = push_req & ((level_q != LVL_FULL) | pop);
  assign drop       = push_req & (level_q == LVL_FULL) & ~pop;
  assign quiet_done = (state_q == ST_BREAK) & ~rx_valid & (idle_cnt_q >= QUIET_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable)     state_d = ST_OFF;
        else if (brk_rx) state_d = ST_BREAK;
      end
      ST_BREAK: begin
        if (!enable)         state_d = ST_OFF;
        else if (quiet_done) state_d = ST_RUN;
      end
      default:  state_d = ST_OFF;
    endcase
  end

  // FIFO pointers, occupancy, show-ahead head and status flags
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // The new head may be the byte written this very cycle (empty FIFO, or 1 entry popped)
    head_from_rx = push_ok & (wr_ptr_q == rd_ptr_d);
    m_data_d = m_data_q;
    if (level_d != '0) m_data_d = head_from_rx ? rx_data : mem_q[rd_ptr_d];

    m_valid_d    = (level_d != '0);
    uart_rx_en_d = (state_d != ST_OFF);
    break_det_d  = brk_rx & (state_q != ST_OFF);

    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // Shared counter: idle time with data buffered in RUN, quiet time in BREAK
  always_comb begin
    brk_edge   = (state_q != state_d) & ((state_q == ST_BREAK) | (state_d == ST_BREAK));
    idle_cnt_d = idle_cnt_q;
    if (brk_edge) begin
      idle_cnt_d = '0;
    end else if (state_q == ST_BREAK) begin
      if (rx_valid)                      idle_cnt_d = '0;
      else if (idle_cnt_q != IDLE_MAX)   idle_cnt_d = idle_cnt_q + 16'd1;
    end else if (push_ok) begin
      idle_cnt_d = '0;
    end else if ((state_q == ST_RUN) && (level_q != '0) && (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
    idle_timeout_d = (state_q == ST_RUN) & (idle_cnt_q != IDLE_MAX) & (idle_cnt_d == IDLE_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_OFF;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      idle_cnt_q     <= '0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      uart_rx_en_q   <= 1'b0;
      overflow_q     <= 1'b0;
      break_det_q    <= 1'b0;
      idle_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      idle_cnt_q     <= idle_cnt_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      uart_rx_en_q   <= uart_rx_en_d;
      overflow_q     <= overflow_d;
      break_det_q    <= break_det_d;
      idle_timeout_q <= idle_timeout_d;
    end
  end

  // Storage array needs no reset: the head register masks stale contents
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef UART_RX_CTRL_EOL_EN
  logic eol_mem_q [FIFO_DEPTH];
  logic rx_eol, m_eol_q, m_eol_d;

  assign rx_eol = (rx_data == PAYLOAD_BITS'(8'h0D)) | (rx_data == PAYLOAD_BITS'(8'h0A));

  always_ff @(posedge clk) begin
    if (push_ok) eol_mem_q[wr_ptr_q] <= rx_eol;
  end

  always_comb begin
    m_eol_d = m_eol_q;
    if (level_d != '0) m_eol_d = head_from_rx ? rx_eol : eol_mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) m_eol_q <= 1'b0;
    else       m_eol_q <= m_eol_d;
  end

  assign m_eol = m_eol_q;
`else
  assign m_eol = 1'b0;
`endif

  assign uart_rx_en   = uart_rx_en_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign break_det    = break_det_q;
  assign idle_timeout = idle_timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed stimulus queues expected bytes, a negedge
// monitor checks every handshake; status outputs checked directly after clock edges.
module tb_uart_rx_ctrl;

  localparam int unsigned PB   = 8;
  localparam int unsigned DEP  = 16;
  localparam int unsigned IDLE = 20;

  logic       clk = 1'b0;
  logic       reset, enable, rx_valid, rx_break, m_ready, ovf_clr;
  logic [7:0] rx_data;
  logic       uart_rx_en, m_valid, m_eol, overflow, break_det, idle_timeout;
  logic [7:0] m_data;
  logic [4:0] level;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  uart_rx_ctrl #(.PAYLOAD_BITS(PB), .FIFO_DEPTH(DEP), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_valid(rx_valid), .rx_break(rx_break),
    .rx_data(rx_data), .uart_rx_en(uart_rx_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_eol(m_eol), .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
    .break_det(break_det), .idle_timeout(idle_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic eol_of(input logic [7:0] d);
    logic e;
    e = (d == 8'h0D) || (d == 8'h0A);
`ifndef UART_RX_CTRL_EOL_EN
    e = 1'b0;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic brk, input logic accept);
    rx_valid = 1'b1;
    rx_break = brk;
    rx_data  = d;
    if (accept) exp_q.push_back(d);
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 4 * DEP; i++) begin
      if (!m_valid) break;
      tick();
    end
    check("drain_empty", m_valid, 1'b0);
    m_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uart_rx_en"}, uart_rx_en, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, 8'h00);
    check({tag, "_m_eol"}, m_eol, 1'b0);
    check({tag, "_level"}, level, 5'd0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_break_det"}, break_det, 1'b0);
    check({tag, "_idle_timeout"}, idle_timeout, 1'b0);
  endtask

  // Monitor: every accepted head entry must match the oldest expected byte
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got data %0h, required no output", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", m_data, mon_exp);
        check("pop_eol", m_eol, eol_of(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;
    reset = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_break = 1'b0;
    rx_data = 8'h00; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Enable: receiver gated on one cycle later
    enable = 1'b1;
    #2;
    check("en_before_edge", uart_rx_en, 1'b0);
    @(posedge clk); #1;
    check("en_after_edge", uart_rx_en, 1'b1);

    // Basic buffering, then back-to-back delivery
    send(8'h41, 1'b0, 1'b1);
    check("first_push_valid", m_valid, 1'b1);
    check("first_push_level", level, 5'd1);
    send(8'h42, 1'b0, 1'b1);
    send(8'h0D, 1'b0, 1'b1);
    check("three_level", level, 5'd3);
    check("three_head", m_data, 8'h41);
    m_ready = 1'b1;
    repeat (3) tick();
    check("three_drained", m_valid, 1'b0);
    check("three_level0", level, 5'd0);
    m_ready = 1'b0;

    // Full FIFO: drop, then push with simultaneous pop, then clear
    for (int i = 0; i < DEP; i++) send(8'(8'h10 + i), 1'b0, 1'b1);
    check("full_level", level, 5'd16);
    check("full_no_ovf", overflow, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    check("drop_ovf", overflow, 1'b1);
    check("drop_level", level, 5'd16);
    m_ready = 1'b1;
    send(8'h66, 1'b0, 1'b1);
    m_ready = 1'b0;
    check("pushpop_level", level, 5'd16);
    check("pushpop_head", m_data, 8'h11);
    check("pushpop_ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    drain();

    // BREAK: pulse, discard during quiet time, resume in RUN
    send(8'h00, 1'b1, 1'b0);
    check("brk_pulse", break_det, 1'b1);
    check("brk_no_push", level, 5'd0);
    check("brk_rx_en", uart_rx_en, 1'b1);
    tick();
    check("brk_pulse_end", break_det, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    check("brk_discard", level, 5'd0);
    check("brk_discard_ovf", overflow, 1'b0);
    repeat (IDLE + 2) tick();
    send(8'h34, 1'b0, 1'b1);
    check("brk_resume_level", level, 5'd1);
    check("brk_resume_head", m_data, 8'h34);
    drain();

    // Idle timeout: one pulse IDLE edges after the push edge, re-armed by a new push
    send(8'h77, 1'b0, 1'b1);
    pulses = 0; first = 0;
    for (int i = 1; i <= 3 * IDLE; i++) begin
      tick();
      if (idle_timeout) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("idle_first_cycle", first, IDLE);
    check("idle_pulse_count", pulses, 1);
    send(8'h78, 1'b0, 1'b1);
    pulses = 0; first = 0;
    for (int i = 1; i <= 2 * IDLE; i++) begin
      tick();
      if (idle_timeout) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("rearm_first_cycle", first, IDLE);
    check("rearm_pulse_count", pulses, 1);
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    // Disable with data buffered, then reset mid-drain
    send(8'hA1, 1'b0, 1'b1);
    send(8'hA2, 1'b0, 1'b1);
    enable = 1'b0;
    #2;
    check("dis_before_edge", uart_rx_en, 1'b1);
    @(posedge clk); #1;
    check("dis_after_edge", uart_rx_en, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    check("off_no_break", break_det, 1'b0);
    send(8'hEE, 1'b0, 1'b0);
    check("off_ignored_level", level, 5'd2);
    check("off_no_ovf", overflow, 1'b0);
    m_ready = 1'b1;
    tick();
    check("off_drain_level", level, 5'd1);
    check("off_drain_head", m_data, 8'hA2);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    m_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
